// File: rtl/sim_sram_burst_ctrl.sv
// Burst controller for the simulation SRAM model: one command becomes LEN word writes (1 cycle/beat) or reads (2 cycles/beat).
// A low wvalid or a low rready stalls the burst in place for as long as it stays low; a zero-length command only pulses done.
module sim_sram_burst_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       start_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_FETCH,
        S_RD_HOLD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [29:0]       r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_cmd_acc;
    logic              w_wr_beat;
    logic              w_rd_beat;
    logic              w_last;
    logic [AW-1:0]     w_idx;
    logic              w_unused_addr_lsb;

    assign w_cmd_acc         = cmd_valid && (r_state == S_IDLE);
    assign w_wr_beat         = wvalid && (r_state == S_WRITE);
    assign w_rd_beat         = rready && (r_state == S_RD_HOLD);
    assign w_last            = (r_beat == r_len - LEN_W'(1));
    assign w_unused_addr_lsb = ^start_addr[1:0];

    // Word index wraps at DEPTH simply by truncating the sum.
    assign w_idx = AW'(r_base + 30'(r_beat));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        w_next = S_DONE;
                    end else if (cmd_write) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_RD_FETCH;
                    end
                end
            end
            S_WRITE: begin
                if (wvalid && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_RD_FETCH: w_next = S_RD_HOLD;
            S_RD_HOLD: begin
                if (rready) begin
                    w_next = w_last ? S_DONE : S_RD_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_cmd_acc) begin
                r_base <= start_addr[31:2];
                r_len  <= cmd_len;
                r_beat <= '0;
            end else if (w_wr_beat || w_rd_beat) begin
                r_beat <= r_beat + LEN_W'(1);
            end
            if (r_state == S_RD_FETCH) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            r_mem[w_idx] <= wdata;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign wready    = (r_state == S_WRITE);
    assign rvalid    = (r_state == S_RD_HOLD);
    assign rdata     = r_rdata;
    assign done      = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_sim_sram_burst_ctrl.sv
// Bench for sim_sram_burst_ctrl: directed and random bursts checked against an array model of the SRAM.
module tb_sim_sram_burst_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int LEN_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       start_addr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [LEN_W-1:0]  cmd_len;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              busy;

    int vecs     = 0;
    int errs     = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [31:0] ref_mem [DEPTH];

    sim_sram_burst_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start_addr(start_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_len(cmd_len),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    function automatic int idx_of(input logic [31:0] a, input int beat);
        return int'(((a >> 2) + 32'(beat)) % DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_vals(input string tag);
        chkb({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chkb({tag, "_wready"}, wready, 1'b0);
        chkb({tag, "_rvalid"}, rvalid, 1'b0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chkb({tag, "_done"}, done, 1'b0);
        chkb({tag, "_busy"}, busy, 1'b0);
    endtask

    // Presents a command in the current IDLE cycle; returns the acceptance edge number.
    task automatic issue(input logic [31:0] a, input logic wr, input int len, output int n);
        cmd_valid  = 1'b1;
        start_addr = a;
        cmd_write  = wr;
        cmd_len    = LEN_W'(len);
        @(negedge clk);
        chkb("cmd_ready", cmd_ready, 1'b1);
        chkb("busy_idle", busy, 1'b0);
        @(posedge clk); #1;
        n          = cyc;
        cmd_valid  = 1'b0;
        start_addr = $urandom;
        cmd_write  = 1'($urandom);
        cmd_len    = LEN_W'($urandom);
    endtask

    task automatic wr_burst(input logic [31:0] a, input int len, input bit rnd, input logic [31:0] d0);
        int n;
        int got = 0;
        int stalls = 0;
        int dc;
        dc = done_cnt;
        issue(a, 1'b1, len, n);
        while (got < len) begin
            wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata  = rnd ? $urandom : d0 + 32'(got);
            @(negedge clk);
            chkb("wr_wready", wready, 1'b1);
            chkb("wr_rvalid", rvalid, 1'b0);
            @(posedge clk); #1;
            if (wvalid) begin
                ref_mem[idx_of(a, got)] = wdata;
                got++;
            end else begin
                stalls++;
            end
        end
        wvalid = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chkb("wr_done", done, 1'b1);
        chk("wr_done_cycle", 32'(cyc + 1), 32'(n + len + 1 + stalls));
        chkb("wr_wready_in_done", wready, 1'b0);
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("wr_done_once", 32'(done_cnt - dc), 32'd1);
    endtask

    // mode 0: rready held high; 1: rready 0,0,1 per beat; 2: random.
    task automatic rd_burst(input logic [31:0] a, input int len, input int mode);
        int n;
        int stalls = 0;
        int dc;
        dc = done_cnt;
        issue(a, 1'b0, len, n);
        for (int b = 0; b < len; b++) begin
            rready = (mode == 0) ? 1'b1 : 1'($urandom);
            @(negedge clk);
            chkb("rd_fetch_rvalid", rvalid, 1'b0);
            chkb("rd_busy", busy, 1'b1);
            @(posedge clk); #1;
            for (int h = 0; h < 8; h++) begin
                rready = (mode == 0) || (mode == 1 && h >= 2) ||
                         (mode == 2 && (h >= 4 || $urandom_range(0, 1) == 1));
                @(negedge clk);
                chkb("rd_rvalid", rvalid, 1'b1);
                chk("rd_rdata", rdata, ref_mem[idx_of(a, b)]);
                @(posedge clk); #1;
                if (rready) break;
                stalls++;
            end
        end
        rready = 1'b1;
        @(negedge clk);
        chkb("rd_done", done, 1'b1);
        chk("rd_done_cycle", 32'(cyc + 1), 32'(n + 2 * len + 1 + stalls));
        chkb("rd_rvalid_in_done", rvalid, 1'b0);
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rd_done_once", 32'(done_cnt - dc), 32'd1);
    endtask

    task automatic zero_len(input logic [31:0] a, input logic wr);
        int n;
        int dc;
        dc = done_cnt;
        issue(a, wr, 0, n);
        wvalid = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        chkb("zl_done", done, 1'b1);
        chk("zl_done_cycle", 32'(cyc + 1), 32'(n + 1));
        chkb("zl_wready", wready, 1'b0);
        chkb("zl_rvalid", rvalid, 1'b0);
        @(posedge clk); #1;
        wvalid = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        chkb("zl_idle_wready", wready, 1'b0);
        chkb("zl_idle_rvalid", rvalid, 1'b0);
        chk("zl_done_once", 32'(done_cnt - dc), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int dc;
        int len;
        int rl;
        logic [31:0] a;

        rst = 1'b1; start_addr = '0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len = '0;
        wvalid = 1'b0; wdata = '0; rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_rst_vals("por");
        rst = 1'b0;

        // Write then read back, plus full-speed timing.
        wr_burst(32'h10, 4, 1'b0, 32'hA0);
        rd_burst(32'h10, 4, 0);

        // Reset in IDLE with rdata holding the last read word.
        rst = 1'b1;
        #1;
        chk_rst_vals("rst_idle");
        @(posedge clk); #1;
        rst = 1'b0;

        // Wrap-around at the top of the array.
        wr_burst(32'h3F8, 4, 1'b0, 32'h1);
        rd_burst(32'h0, 2, 0);
        rd_burst(32'h3F8, 4, 2);

        // Read back-pressure, 0,0,1 per beat.
        rd_burst(32'h10, 3, 1);

        zero_len(32'h40, 1'b1);
        zero_len(32'h40, 1'b0);

        // Reset part-way into a 5-beat write over a known region.
        wr_burst(32'h200, 5, 1'b1, 32'h0);
        dc = done_cnt;
        issue(32'h200, 1'b1, 5, n);
        for (int b = 0; b < 2; b++) begin
            wvalid = 1'b1;
            wdata  = 32'h5500 + 32'(b);
            @(posedge clk); #1;
            ref_mem[idx_of(32'h200, b)] = wdata;
        end
        wvalid = 1'b1;
        wdata  = 32'hBAD0_0BAD;
        rst    = 1'b1;
        #1;
        chk_rst_vals("rst_mid_wr");
        @(posedge clk); #1;
        rst    = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chkb("rst_mid_wr_no_done", done, 1'b0);
        @(posedge clk); #1;
        chk("rst_mid_wr_done_cnt", 32'(done_cnt - dc), 32'd0);
        rd_burst(32'h200, 5, 0);

        // Random bursts, with random address LSBs on read-back.
        for (int it = 0; it < 12; it++) begin
            a   = $urandom;
            len = $urandom_range(1, 31);
            wr_burst(a, len, 1'b1, 32'h0);
            rl  = $urandom_range(1, len);
            rd_burst({a[31:2], 2'($urandom)}, rl, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sim_sram_burst_ctrl.md
# sim_sram_burst_ctrl

Burst access controller for the simulation SRAM model. It consumes the `start_addr` variable published by the `sim_sram_if` interface and turns one accepted command into a sequence of word writes or reads of that address region. Data moves through valid/ready handshakes, and the memory array is held inside the block. Simulation and synthesis-check flows use it to exercise the SRAM model.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits.
- `DEPTH`, 256: number of words in the internal array; must be a power of two.
- `LEN_W`, 5: width of the burst-length field; the maximum burst is 2^LEN_W − 1 beats (31).

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start_addr`, in, 32: byte address taken from `sim_sram_if.start_addr`. It is sampled only when a command is accepted.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: high only in IDLE.
- `cmd_write`, in, 1: 1 = write burst, 0 = read burst.
- `cmd_len`, in, LEN_W: number of beats. A value of 0 is accepted and does no work.
- `wvalid`, in, 1: write data valid.
- `wready`, out, 1: high only in WRITE.
- `wdata`, in, DATA_W: write beat.
- `rvalid`, out, 1: read data valid.
- `rready`, in, 1: read data accepted.
- `rdata`, out, DATA_W: read beat.
- `done`, out, 1: one-cycle pulse when a burst completes.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- **Word index:** index = (start_addr[31:2] + beat) mod DEPTH.
  - start_addr[1:0] is ignored.
  - The index wraps silently at DEPTH.
- **Command acceptance:** a command is accepted when `cmd_valid && cmd_ready`. On acceptance the block latches `start_addr[31:2]`, `cmd_write`, `cmd_len`, and clears the beat counter.
- **States:**
  - IDLE → WRITE, when an accepted command has cmd_write=1 and len≠0.
  - IDLE → RD_FETCH, when an accepted command has cmd_write=0 and len≠0.
  - IDLE → DONE, when an accepted command has len=0.
  - WRITE: on `wvalid && wready`, mem[index] ← wdata and beat++. After the last beat (beat==len−1) → DONE.
  - RD_FETCH: read mem[index] into the rdata register → RD_HOLD.
  - RD_HOLD: rvalid=1 and rdata is stable.
    - On `rready`: beat++. Go to DONE if this was the last beat, otherwise back to RD_FETCH.
    - rdata must not change while rvalid=1 and rready=0.
  - DONE: done=1 for exactly one cycle → IDLE.
- **Write path:** wdata is ignored outside WRITE.
- **Read path:** rvalid is never high outside RD_HOLD.
- **Memory contents:** the array is not cleared by reset. Reads of locations never written return X in simulation. The bench must write before it reads.
- **Back-to-back commands:** a new command cannot be accepted in the DONE cycle, because cmd_ready=0. The earliest next acceptance is the first cycle in IDLE.
- **Reset mid-burst:** reset asserted in any state forces IDLE immediately, abandoning the burst. No done pulse is issued for the abandoned burst. Words already written stay in the memory.

## Timing
- **Reset values:** cmd_ready=1, wready=0, rvalid=0, rdata=0, done=0, busy=0, beat=0.
- **Write timing:**
  - Acceptance at edge N puts the block in WRITE from cycle N+1.
  - With wvalid held high, L beats take L cycles.
  - done is high in cycle N+L+1.
  - IDLE with cmd_ready=1 resumes at cycle N+L+2.
- **Read timing:**
  - Acceptance at edge N gives RD_FETCH in cycle N+1 and first rvalid in cycle N+2.
  - With rready held high, each beat costs 2 cycles (fetch + hold), so L beats take 2L cycles.
  - done is high in cycle N+2L+1.
- **Zero-length command:** acceptance at edge N gives done in cycle N+1. wready and rvalid never assert.
- **Back-pressure:** wvalid low or rready low stalls the block in its current state indefinitely, with no timeout.
- **Simultaneous events:** reset takes priority over any handshake in the same cycle.

## Test plan
1. **Reset:** assert rst mid-simulation → all outputs match the reset values in the same cycle.
2. **Write then read back:**
   - Write burst with start_addr=0x10, len=4, data 0xA0..0xA3 → done in cycle N+5.
   - Read burst at 0x10, len=4, rready=1 → rdata sequence A0,A1,A2,A3; rvalid every other cycle; done at N+9.
3. **Wrap-around:** DEPTH=256, start_addr=0x3F8, write len=4 of 1,2,3,4 → words 254,255,0,1 hold 1,2,3,4. Read of 2 words at 0x0 returns 3,4.
4. **Back-pressure:** read len=3 with rready toggling 0,0,1 per beat → rdata stable while rvalid high and rready low; total beats = 3; done pulses exactly once.
5. **Zero length:** cmd_len=0 → done in cycle N+1; no wready or rvalid activity.
6. **Reset mid-write:** assert rst after 2 of 5 beats → busy=0 immediately; no done pulse; the two written words read back correctly after a fresh read command.
